// File: rtl/debounce_pkg.sv
// debounce_pkg: shared timing defaults and sizing helpers for the debouncer.
package debounce_pkg;
  localparam int CLK_HZ = 25_000_000;
  localparam int DEBOUNCE_MS = 10;
  localparam int REPEAT_DELAY_MS = 300;
  localparam int REPEAT_PERIOD_MS = 100;
  function automatic int ms_to_cycles(input int ms);
    return (CLK_HZ / 1000) * ms;
  endfunction
  function automatic int cnt_width(input int max);
    return $clog2(max + 1);
  endfunction
endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: synchroniser, stability counter, level/pulse and optional auto-repeat for one input.
// Auto-repeat is built only when DEBOUNCE_REPEAT_EN is defined.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 250000,
  parameter int SYNC_STAGES = 2,
  parameter int REPEAT_DELAY = 7500000,
  parameter int REPEAT_PERIOD = 2500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press,
  output logic rel,
  output logic rep
);
  localparam int CW = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES);
  logic [SYNC_STAGES-1:0] sync;
  logic cand;
  logic [CW-1:0] cnt;
  logic s;
  logic mature;
  assign s = sync[SYNC_STAGES-1];
  // the edge on which level adopts cand
  assign mature = (s == cand) && (cnt == CMAX) && (cand != level);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync <= '0;
      cand <= 1'b0;
      cnt <= '0;
      level <= 1'b0;
      press <= 1'b0;
      rel <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], raw};
      press <= 1'b0;
      rel <= 1'b0;
      if (s != cand) begin
        cand <= s;
        cnt <= '0;
      end else if (cnt != CMAX) begin
        cnt <= cnt + CW'(1);
      end else if (mature) begin
        level <= cand;
        press <= cand;
        rel <= ~cand;
      end
    end
  end
`ifdef DEBOUNCE_REPEAT_EN
  localparam int RW = cnt_width(REPEAT_DELAY);
  localparam logic [RW-1:0] RFIRE = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RLOAD = RW'(REPEAT_DELAY - REPEAT_PERIOD);
  logic [RW-1:0] rcnt;
  // mature covers both the press and the release edge, so neither carries a repeat
  always_ff @(posedge clk) begin
    if (!rst_n || !level || mature) begin
      rcnt <= '0;
      rep <= 1'b0;
    end else if (rcnt == RFIRE) begin
      rcnt <= RLOAD;
      rep <= 1'b1;
    end else begin
      rcnt <= rcnt + RW'(1);
      rep <= 1'b0;
    end
  end
`else
  assign rep = 1'b0;
`endif
endmodule

// File: rtl/debouncer_multi.sv
// debouncer_multi: NUM_CH independent switch debouncers with press/release pulses.
// Define DEBOUNCE_REPEAT_EN to enable the held-key auto-repeat pulse on repeat_o.
module debouncer_multi
  import debounce_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int STABLE_CYCLES = ms_to_cycles(DEBOUNCE_MS),
  parameter int SYNC_STAGES = 2,
  parameter logic [NUM_CH-1:0] INVERT_MASK = '0,
  parameter int REPEAT_DELAY = ms_to_cycles(REPEAT_DELAY_MS),
  parameter int REPEAT_PERIOD = ms_to_cycles(REPEAT_PERIOD_MS)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [NUM_CH-1:0] raw_i,
  output logic [NUM_CH-1:0] level_o,
  output logic [NUM_CH-1:0] press_o,
  output logic [NUM_CH-1:0] release_o,
  output logic [NUM_CH-1:0] repeat_o
);
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .SYNC_STAGES(SYNC_STAGES),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_ch (
      .clk(clk),
      .rst_n(rst_n),
      .raw(raw_i[g] ^ INVERT_MASK[g]),
      .level(level_o[g]),
      .press(press_o[g]),
      .rel(release_o[g]),
      .rep(repeat_o[g])
    );
  end
endmodule
